// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: forward AES SubBytes over a 128-bit state.
// The engine substitutes LANES bytes per cycle with valid/ready handshakes
// on both sides, and holds the result until the consumer takes it.
module sub_bytes_engine #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned NCYC = 16 / LANES;
    localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
            $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // FIPS-197 forward S-box, entry 0 in the most significant byte
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  cnt_q;
    logic [127:0]   work_q;
    logic [127:0]   work_d;
    logic [127:0]   out_q;
    int unsigned    base;

    assign base     = LANES * {{(32 - CW){1'b0}}, cnt_q};
    assign out_data = out_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Substitute the LANES bytes selected by the counter, byte 0 first
    always_comb begin
        work_d = work_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            work_d[127 - 8 * (base + l) -: 8] = sbox(work_q[127 - 8 * (base + l) -: 8]);
        end
    end

    // Working register, lane counter and held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            work_q <= '0;
            out_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q <= in_data;
                        cnt_q  <= '0;
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    if (cnt_q == LAST) begin
                        // result register is loaded with the final lanes already substituted
                        cnt_q <= '0;
                        out_q <= work_d;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Testbench for sub_bytes_engine: three instances (LANES = 4, 1, 16)
// checked against an S-box derived from GF(2^8) arithmetic.
module tb_sub_bytes_engine;

    logic         clk;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];

    int checks = 0;
    int errors = 0;
    int ncyc [3] = '{4, 16, 1};

    logic [7:0] sbox_m [256];
    logic [7:0] inv_m  [256];

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t tbl [4];

    sub_bytes_engine #(.LANES(4)) u_l4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0])
    );

    sub_bytes_engine #(.LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1])
    );

    sub_bytes_engine #(.LANES(16)) u_l16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_model();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_m[x] = s;
            inv_m[s]  = 8'(x);
        end
    endtask

    function automatic logic [127:0] sub_model(input logic [127:0] din);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            r[127 - 8 * j -: 8] = sbox_m[din[127 - 8 * j -: 8]];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits (from #1 after the acceptance edge) for out_valid, toggling inputs meanwhile
    task automatic wait_done(input int k, output int lat);
        lat = 0;
        while (out_valid[k] !== 1'b1 && lat < 64) begin
            chk($sformatf("busy_in_ready_low[%0d]", k), 128'(in_ready[k]), 128'd0);
            in_valid[k] = 1'($urandom);
            in_data[k]  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            lat++;
        end
        in_valid[k] = 1'b0;
    endtask

    task automatic run_txn(input int k, input logic [127:0] din, output logic [127:0] dout, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (in_ready[k] !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) chk($sformatf("in_ready_timeout[%0d]", k), 128'(in_ready[k]), 128'd1);
        in_valid[k] = 1'b1;
        in_data[k]  = din;
        @(posedge clk); #1;
        chk($sformatf("accept_busy[%0d]", k), 128'(busy[k]), 128'd1);
        wait_done(k, lat);
        dout = out_data[k];
    endtask

    task automatic release_out(input int k, input logic [127:0] held);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        chk($sformatf("rel_out_valid[%0d]", k), 128'(out_valid[k]), 128'd0);
        chk($sformatf("rel_in_ready[%0d]", k), 128'(in_ready[k]), 128'd1);
        chk($sformatf("rel_busy[%0d]", k), 128'(busy[k]), 128'd0);
        chk($sformatf("rel_hold_data[%0d]", k), out_data[k], held);
    endtask

    initial begin
        logic [127:0] din;
        logic [127:0] dout;
        logic [127:0] rec;
        int lat;

        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b0;
        end
        rst_n = 1'b0;
        build_model();

        tbl[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
        tbl[1] = '{128'h00000000000000000000000000000000, 128'h63636363636363636363636363636363};
        tbl[2] = '{128'hffffffffffffffffffffffffffffffff, 128'h16161616161616161616161616161616};
        tbl[3] = '{128'h000153ff000153ff000153ff000153ff, 128'h637ced16637ced16637ced16637ced16};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_in_ready[%0d]", k), 128'(in_ready[k]), 128'd1);
            chk($sformatf("reset_out_valid[%0d]", k), 128'(out_valid[k]), 128'd0);
            chk($sformatf("reset_out_data[%0d]", k), out_data[k], 128'd0);
            chk($sformatf("reset_busy[%0d]", k), 128'(busy[k]), 128'd0);
        end

        // Table vectors on every lane width
        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 4; v++) begin
                run_txn(k, tbl[v].din, dout, lat);
                chk($sformatf("tbl_data[%0d][%0d]", k, v), dout, tbl[v].dout);
                chk($sformatf("tbl_latency[%0d][%0d]", k, v), 128'(lat), 128'(ncyc[k]));
                release_out(k, tbl[v].dout);
            end
        end

        // Random states against the model
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 15; r++) begin
                din = {$urandom, $urandom, $urandom, $urandom};
                run_txn(k, din, dout, lat);
                chk($sformatf("rand_data[%0d][%0d]", k, r), dout, sub_model(din));
                chk($sformatf("rand_latency[%0d][%0d]", k, r), 128'(lat), 128'(ncyc[k]));
                release_out(k, sub_model(din));
            end
        end

        // Consumer stalls for 10 cycles in DONE while inputs toggle
        run_txn(0, tbl[0].din, dout, lat);
        for (int c = 0; c < 10; c++) begin
            in_valid[0] = 1'($urandom);
            in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            chk("stall_out_valid", 128'(out_valid[0]), 128'd1);
            chk("stall_out_data", out_data[0], tbl[0].dout);
            chk("stall_in_ready", 128'(in_ready[0]), 128'd0);
        end
        in_valid[0] = 1'b0;
        release_out(0, tbl[0].dout);

        // out_ready held high before DONE: one-cycle out_valid pulse
        out_ready[1] = 1'b1;
        run_txn(1, tbl[2].din, dout, lat);
        chk("early_ready_latency", 128'(lat), 128'd16);
        chk("early_ready_data", dout, tbl[2].dout);
        @(posedge clk); #1;
        chk("early_ready_out_valid", 128'(out_valid[1]), 128'd0);
        chk("early_ready_in_ready", 128'(in_ready[1]), 128'd1);
        out_ready[1] = 1'b0;

        // Reset during BUSY aborts; in_valid during reset is not accepted
        din = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = din;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        chk("pre_abort_busy", 128'(busy[0]), 128'd1);
        rst_n = 1'b0;
        din = {$urandom, $urandom, $urandom, $urandom};
        in_valid[0] = 1'b1;
        in_data[0]  = din;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("abort_out_valid[%0d]", k), 128'(out_valid[k]), 128'd0);
            chk($sformatf("abort_busy[%0d]", k), 128'(busy[k]), 128'd0);
            chk($sformatf("abort_out_data[%0d]", k), out_data[k], 128'd0);
        end
        @(posedge clk); #1;
        chk("reset_no_accept", 128'(busy[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_accept_after_reset", 128'(busy[0]), 128'd1);
        wait_done(0, lat);
        chk("post_reset_latency", 128'(lat), 128'd4);
        chk("post_reset_data", out_data[0], sub_model(din));
        release_out(0, sub_model(din));

        // All 256 byte values back-to-back, recovered through the inverse S-box
        out_ready[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) din[127 - 8 * j -: 8] = 8'(16 * i + j);
            run_txn(0, din, dout, lat);
            for (int j = 0; j < 16; j++) rec[127 - 8 * j -: 8] = inv_m[dout[127 - 8 * j -: 8]];
            chk($sformatf("inverse_recover[%0d]", i), rec, din);
            chk($sformatf("exh_latency[%0d]", i), 128'(lat), 128'd4);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        chk("exh_final_idle", 128'(in_ready[0]), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
